// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester TX/RX pair: FSM encoding, framing
// bytes and the half-bit mapping (data 1 -> 0,1 ; data 0 -> 1,0).
package manchester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        DRAIN,
        GAP
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // First half carries the inverted bit, second half the bit itself.
    function automatic logic manchester_half(input logic data_bit, input logic half);
        return half ? data_bit : ~data_bit;
    endfunction

endpackage

// File: rtl/manchester_tick_gen.sv
// Half-bit timebase: counts HALF_BIT_CLKS aclk cycles and flags the last
// cycle of every half-bit with step. Held at zero while clear is high so the
// first half-bit after clear lasts a full HALF_BIT_CLKS cycles.
module manchester_tick_gen #(
    parameter int HALF_BIT_CLKS = 1
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    output logic step
);

    localparam int            TW       = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(HALF_BIT_CLKS - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    assign step = (tick_q == TICK_MAX);

    // Next tick value: wrap on the last cycle of a half-bit, hold zero on clear.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        tick_d = tick_q;
        if (clear || step) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    // Tick register with asynchronous reset.
    always_ff @(posedge aclk or posedge areset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (areset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/manchester_encoder_tx.sv
// Manchester transmitter: takes payload bytes from an AXI-stream slave, frames
// them as preamble (0xAA x PREAMBLE_BYTES), SFD (0xD5) and payload, and
// serialises each bit MSB-first as two half-bits on tx_line. A missing byte
// mid-frame ends the line activity, flags underrun and drains the rest of the
// packet; every frame is followed by an inter-frame gap of 2*IFG_BITS halves.
module manchester_encoder_tx
    import manchester_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 2,
    parameter int HALF_BIT_CLKS  = 1,
    parameter int IFG_BITS       = 12
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic       tx_line,
    output logic       tx_en,
    output logic       busy,
    output logic       underrun
);

    localparam int            GAP_HALVES = 2 * IFG_BITS;
    localparam int            GW         = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_HALVES - 1);
    localparam logic [3:0]    PRE_LAST   = 4'(PREAMBLE_BYTES - 1);

    state_t       state_q,    state_d;
    logic [7:0]   sreg_q,     sreg_d;
    logic         half_q,     half_d;
    logic [2:0]   bit_cnt_q,  bit_cnt_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic         last_q,     last_d;
    logic         tx_line_q,  tx_line_d;
    logic         tx_en_q,    tx_en_d;

    logic step;
    logic byte_done;
    logic start_frame;
    logic tready_c;
    logic underrun_c;
    logic tick_clear;

    // The divider idles in IDLE and DRAIN, so both the first preamble
    // half-bit and the gap that follows a drain start on a fresh tick.
    assign tick_clear = (state_q == IDLE) || (state_q == DRAIN);

    manchester_tick_gen #(
        .HALF_BIT_CLKS (HALF_BIT_CLKS)
    ) u_tick_gen (
        .aclk   (aclk),
        .areset (areset),
        .clear  (tick_clear),
        .step   (step)
    );

    // Next-state, counters, shift register and line value for the next cycle.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        half_d      = half_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_d      = last_q;
        tx_en_d     = 1'b0;
        tready_c    = 1'b0;
        underrun_c  = 1'b0;
        start_frame = 1'b0;
        // Load slot: last tick of the second half of bit 0 of the current byte.
        byte_done   = step && half_q && (bit_cnt_q == 3'd0);

        case (state_q)
            IDLE: begin
                // The waiting beat is left in place; it is consumed at the SFD load slot.
                start_frame = s_axis_tvalid;
            end

            PRE, SFD, DATA: begin
                tx_en_d = 1'b1;
                if (step && !half_q) begin
                    half_d = 1'b1;
                end else if (step && (bit_cnt_q != 3'd0)) begin
                    half_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    sreg_d    = {sreg_q[6:0], 1'b0};
                end else if (byte_done) begin
                    half_d    = 1'b0;
                    bit_cnt_d = 3'd7;
                    case (state_q)
                        PRE: begin
                            if (byte_cnt_q == PRE_LAST) begin
                                byte_cnt_d = 4'd0;
                                sreg_d     = SFD_BYTE;
                                state_d    = SFD;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 4'd1;
                                sreg_d     = PREAMBLE_BYTE;
                            end
                        end
                        SFD: begin
                            if (s_axis_tvalid) begin
                                tready_c = 1'b1;
                                sreg_d   = s_axis_tdata;
                                last_d   = s_axis_tlast;
                                state_d  = DATA;
                            end else begin
                                // No payload at all: nothing left to drain.
                                underrun_c = 1'b1;
                                tx_en_d    = 1'b0;
                                gap_cnt_d  = '0;
                                state_d    = GAP;
                            end
                        end
                        default: begin
                            if (last_q) begin
                                tx_en_d   = 1'b0;
                                gap_cnt_d = '0;
                                state_d   = GAP;
                            end else if (s_axis_tvalid) begin
                                tready_c = 1'b1;
                                sreg_d   = s_axis_tdata;
                                last_d   = s_axis_tlast;
                            end else begin
                                underrun_c = 1'b1;
                                tx_en_d    = 1'b0;
                                state_d    = DRAIN;
                            end
                        end
                    endcase
                end
            end

            DRAIN: begin
                // Swallow the rest of the broken packet up to its tlast.
                tready_c = s_axis_tvalid;
                if (s_axis_tvalid && s_axis_tlast) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end

            GAP: begin
                if (step) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        // The gap's final cycle doubles as the IDLE decision
                        // point, so queued frames are separated by exactly the gap.
                        if (s_axis_tvalid) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_frame) begin
            state_d    = PRE;
            sreg_d     = PREAMBLE_BYTE;
            half_d     = 1'b0;
            bit_cnt_d  = 3'd7;
            byte_cnt_d = 4'd0;
            last_d     = 1'b0;
            tx_en_d    = 1'b1;
        end

        // The registered line shows the half-bit selected by the next counters.
        tx_line_d = tx_en_d ? manchester_half(sreg_d[7], half_d) : 1'b0;
    end

    // State, counters and registered line outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            half_q     <= 1'b0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            last_q     <= 1'b0;
            tx_line_q  <= 1'b0;
            tx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            half_q     <= half_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            last_q     <= last_d;
            tx_line_q  <= tx_line_d;
            tx_en_q    <= tx_en_d;
        end
    end

    assign s_axis_tready = tready_c;
    assign underrun      = underrun_c;
    assign tx_line       = tx_line_q;
    assign tx_en         = tx_en_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_manchester_encoder_tx.sv
// Directed bench for manchester_encoder_tx. Three instances cover the default
// configuration, PREAMBLE_BYTES=1/HALF_BIT_CLKS=4 and PREAMBLE_BYTES=1; only
// the selected one sees tvalid and is recorded each cycle on the falling edge.
module tb_manchester_encoder_tx;

    localparam int B_LINE = 0;
    localparam int B_EN   = 1;
    localparam int B_RDY  = 2;
    localparam int B_UND  = 3;
    localparam int B_BUSY = 4;

    logic       aclk;
    logic       areset;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic [1:0] sel;
    logic       rec_on;

    logic [2:0] tvalid_v;
    logic [2:0] tready_v, tx_line_v, tx_en_v, busy_v, underrun_v;
    logic       tready_s, tx_line_s, tx_en_s, busy_s, underrun_s;

    int n_vec  = 0;
    int n_miss = 0;

    logic [4:0] rec[$];
    logic [7:0] tx_b[16];
    logic       tl_b[16];
    logic [7:0] exp_b[16];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    assign tvalid_v[0] = tvalid && (sel == 2'd0);
    assign tvalid_v[1] = tvalid && (sel == 2'd1);
    assign tvalid_v[2] = tvalid && (sel == 2'd2);

    assign tready_s   = tready_v[sel];
    assign tx_line_s  = tx_line_v[sel];
    assign tx_en_s    = tx_en_v[sel];
    assign busy_s     = busy_v[sel];
    assign underrun_s = underrun_v[sel];

    manchester_encoder_tx u_dut0 (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid_v[0]),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready_v[0]),
        .tx_line       (tx_line_v[0]),
        .tx_en         (tx_en_v[0]),
        .busy          (busy_v[0]),
        .underrun      (underrun_v[0])
    );

    manchester_encoder_tx #(
        .PREAMBLE_BYTES (1),
        .HALF_BIT_CLKS  (4)
    ) u_dut1 (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid_v[1]),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready_v[1]),
        .tx_line       (tx_line_v[1]),
        .tx_en         (tx_en_v[1]),
        .busy          (busy_v[1]),
        .underrun      (underrun_v[1])
    );

    manchester_encoder_tx #(
        .PREAMBLE_BYTES (1)
    ) u_dut2 (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid_v[2]),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready_v[2]),
        .tx_line       (tx_line_v[2]),
        .tx_en         (tx_en_v[2]),
        .busy          (busy_v[2]),
        .underrun      (underrun_v[2])
    );

    // Per-cycle trace of the selected instance, sampled mid-cycle.
    always @(negedge aclk) begin
        if (rec_on) rec.push_back({busy_s, underrun_s, tready_s, tx_en_s, tx_line_s});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int b, input logic v, input int from);
        for (int i = from; i < rec.size(); i++) if (rec[i][b] == v) return i;
        return -1;
    endfunction

    function automatic int count(input int b);
        int c = 0;
        for (int i = 0; i < rec.size(); i++) if (rec[i][b]) c++;
        return c;
    endfunction

    function automatic int nth(input int b, input int n);
        int c = 0;
        for (int i = 0; i < rec.size(); i++) begin
            if (rec[i][b]) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [127:0] line_vec(input int start, input int n, input int stride);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            int k;
            k = start + i * stride;
            v = {v[126:0], (k >= 0 && k < rec.size()) ? rec[k][B_LINE] : 1'b0};
        end
        return v;
    endfunction

    // Bench-side Manchester reference over exp_b[0..n-1], MSB first.
    function automatic logic [127:0] manch(input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--) v = {v[125:0], ~exp_b[i][b], exp_b[i][b]};
        return v;
    endfunction

    // Loopback decoder: data bit is the second half of each pair.
    function automatic logic [7:0] dec_byte(input int start);
        logic [7:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) begin
            int k;
            k = start + 2 * b + 1;
            v = {v[6:0], (k >= 0 && k < rec.size()) ? rec[k][B_LINE] : 1'b0};
        end
        return v;
    endfunction

    task automatic beat(input int i, input logic [7:0] d, input logic l);
        tx_b[i] = d;
        tl_b[i] = l;
    endtask

    task automatic wait_ready;
        int k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (!tready_s && k < 2000);
        if (!tready_s) check("handshake_timeout", 0, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beats(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            tdata  = tx_b[i];
            tlast  = tl_b[i];
            tvalid = 1'b1;
            wait_ready();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_idle;
        int k = 0;
        while (busy_s && k < 3000) begin
            @(negedge aclk);
            k++;
        end
        if (busy_s) check("idle_timeout", 0, 1);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic start_rec;
        rec.delete();
        rec_on = 1'b1;
    endtask

    initial begin
        int s, e, r, u, i3, i4, viol;

        areset = 1'b1;
        tvalid = 1'b0;
        tdata  = 8'h00;
        tlast  = 1'b0;
        sel    = 2'd0;
        rec_on = 1'b0;

        // Reset state, with a beat already offered.
        repeat (2) @(posedge aclk);
        #1;
        tvalid = 1'b1;
        #1;
        check("rst_tx_line", tx_line_s, 0);
        check("rst_tx_en", tx_en_s, 0);
        check("rst_tready", tready_s, 0);
        check("rst_busy", busy_s, 0);
        check("rst_underrun", underrun_s, 0);
        tvalid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Frame AA BB CC DD, defaults, tvalid held.
        beat(0, 8'hAA, 0); beat(1, 8'hBB, 0); beat(2, 8'hCC, 0); beat(3, 8'hDD, 1);
        start_rec();
        send_beats(0, 4);
        wait_idle();
        rec_on = 1'b0;
        s = find(B_EN, 1, 0);
        e = find(B_EN, 0, s);
        check("t1_latency", s, 1);
        check("t1_en_len", e - s, 112);
        check("t1_en_total", count(B_EN), 112);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hAA; exp_b[2] = 8'hD5; exp_b[3] = 8'hAA;
        exp_b[4] = 8'hBB; exp_b[5] = 8'hCC; exp_b[6] = 8'hDD;
        check("t1_line", line_vec(s, 112, 1), manch(7));
        check("t1_first4", line_vec(s, 4, 1), 4'b0110);
        check("t1_ready_cnt", count(B_RDY), 4);
        for (int k = 0; k < 4; k++) check("t1_ready_pos", nth(B_RDY, k), s + 47 + 16 * k);
        for (int k = 0; k < 4; k++) check("t1_loopback", dec_byte(s + 48 + 16 * k), tx_b[k]);
        check("t1_underrun", count(B_UND), 0);
        check("t1_idle_at", find(B_BUSY, 0, s), e + 24);

        // Two frames queued back-to-back: {11} then {22 33}.
        beat(0, 8'h11, 1); beat(1, 8'h22, 0); beat(2, 8'h33, 1);
        start_rec();
        send_beats(0, 3);
        wait_idle();
        rec_on = 1'b0;
        s = find(B_EN, 1, 0);
        e = find(B_EN, 0, s);
        r = find(B_EN, 1, e);
        check("t2_f1_len", e - s, 64);
        check("t2_gap_len", r - e, 24);
        check("t2_gap_line", line_vec(e, 24, 1), 0);
        check("t2_f2_len", find(B_EN, 0, r) - r, 80);
        check("t2_f2_start", line_vec(r, 2, 1), 2'b01);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hAA; exp_b[2] = 8'hD5; exp_b[3] = 8'h22; exp_b[4] = 8'h33;
        check("t2_f2_line", line_vec(r, 80, 1), manch(5));

        // Underrun after the 2nd payload byte of a 4-byte frame.
        beat(0, 8'hA1, 0); beat(1, 8'hA2, 0); beat(2, 8'hA3, 0); beat(3, 8'hA4, 1);
        start_rec();
        send_beats(0, 2);
        repeat (30) @(posedge aclk);
        #1;
        send_beats(2, 2);
        wait_idle();
        rec_on = 1'b0;
        s  = find(B_EN, 1, 0);
        e  = find(B_EN, 0, s);
        u  = find(B_UND, 1, 0);
        i3 = nth(B_RDY, 2);
        i4 = nth(B_RDY, 3);
        check("t3_en_len", e - s, 80);
        check("t3_en_total", count(B_EN), 80);
        check("t3_underrun_pos", u, e - 1);
        check("t3_underrun_cnt", count(B_UND), 1);
        check("t3_ready_cnt", count(B_RDY), 4);
        check("t3_drain_pair", i4 - i3, 1);
        check("t3_idle_at", find(B_BUSY, 0, s), i4 + 25);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hAA; exp_b[2] = 8'hD5; exp_b[3] = 8'hA1; exp_b[4] = 8'hA2;
        check("t3_line", line_vec(s, 80, 1), manch(5));

        // HALF_BIT_CLKS=4, PREAMBLE_BYTES=1, single byte 0x0F.
        sel = 2'd1;
        beat(0, 8'h0F, 1);
        start_rec();
        send_beats(0, 1);
        wait_idle();
        rec_on = 1'b0;
        s = find(B_EN, 1, 0);
        e = find(B_EN, 0, s);
        check("t4_latency", s, 1);
        check("t4_en_len", e - s, 192);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hD5; exp_b[2] = 8'h0F;
        check("t4_line", line_vec(s, 48, 4), manch(3));
        viol = 0;
        for (int g = 0; g < 48; g++)
            for (int j = 1; j < 4; j++)
                if (rec[s + 4 * g + j][B_LINE] != rec[s + 4 * g][B_LINE]) viol++;
        check("t4_hold_viol", viol, 0);
        check("t4_ready_pos", nth(B_RDY, 0), s + 127);
        check("t4_ready_cnt", count(B_RDY), 1);

        // areset during bit 3 of payload byte 2, then a fresh frame.
        sel    = 2'd0;
        tdata  = 8'h5A;
        tlast  = 1'b0;
        tvalid = 1'b1;
        repeat (73) @(posedge aclk);
        #1;
        check("t5_pre_tx_en", tx_en_s, 1);
        #2;
        areset = 1'b1;
        #1;
        check("t5_rst_tx_en", tx_en_s, 0);
        check("t5_rst_tx_line", tx_line_s, 0);
        check("t5_rst_tready", tready_s, 0);
        check("t5_rst_busy", busy_s, 0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        #2;
        check("t5_rel_tx_en", tx_en_s, 0);
        @(posedge aclk);
        #1;
        check("t5_restart_en", tx_en_s, 1);
        check("t5_restart_h0", tx_line_s, 0);
        @(posedge aclk);
        #1;
        check("t5_restart_h1", tx_line_s, 1);
        tvalid = 1'b0;
        wait_idle();

        // tvalid with tlast in IDLE, data 0x00, PREAMBLE_BYTES=1.
        sel = 2'd2;
        beat(0, 8'h00, 1);
        start_rec();
        send_beats(0, 1);
        wait_idle();
        rec_on = 1'b0;
        s = find(B_EN, 1, 0);
        e = find(B_EN, 0, s);
        check("t6_en_len", e - s, 48);
        check("t6_payload", line_vec(s + 32, 16, 1), 16'hAAAA);
        check("t6_ready_pos", nth(B_RDY, 0), s + 31);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hD5; exp_b[2] = 8'h00;
        check("t6_line", line_vec(s, 48, 1), manch(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
